// File: rtl/key_matrix_emulator_pkg.sv
// Shared definitions for the 4x8 piano key matrix, used by the emulator and the scanner datapath.
package piano_kbd_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 8;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [4:0] key_idx_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_BOUNCE = 1'b1
    } emu_state_t;

    function automatic key_idx_t key_idx(input int row, input int col);
        return key_idx_t'(row * NUM_COLS + col);
    endfunction

endpackage

// File: rtl/key_matrix_emulator_if.sv
// Valid/ready command port that sets the emulated key state.
interface key_matrix_emulator_if;
    import piano_kbd_pkg::*;

    logic     cmd_valid;
    logic     cmd_ready;
    key_idx_t cmd_key;
    logic     cmd_press;

    modport master (
        output cmd_valid,
        output cmd_key,
        output cmd_press,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        input  cmd_press,
        output cmd_ready
    );

endinterface

// File: rtl/key_matrix_emulator_bounce.sv
// Contact-bounce generator: down-counting toggle timer, toggle counter and phase register.
module key_bounce_gen #(
    parameter int TOGGLE_CYCLES  = 50000,
    parameter int BOUNCE_TOGGLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_phase_init,
    input  logic i_settled,
    output logic o_phase,
    output logic o_done
);

    localparam int TMR_W = (TOGGLE_CYCLES > 1) ? $clog2(TOGGLE_CYCLES) : 1;
    localparam int CNT_W = (BOUNCE_TOGGLES > 0) ? $clog2(BOUNCE_TOGGLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TOGGLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOUNCE_TOGGLES);

    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_count;
    logic             r_active;
    logic             r_phase;
    logic             w_tick;
    logic             w_last;

    assign w_tick = r_active && (r_timer == '0);
    assign w_last = w_tick && ((r_count + 1'b1) == CNT_LAST);

    // The final toggle lands on the settled level instead of inverting, so odd counts still end clean.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_timer  <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
            r_phase  <= 1'b0;
        end else if (i_start) begin
            r_timer  <= TMR_LOAD;
            r_count  <= '0;
            r_active <= 1'b1;
            r_phase  <= i_phase_init;
        end else if (w_tick) begin
            r_timer <= TMR_LOAD;
            if (w_last) begin
                r_count  <= CNT_LAST;
                r_active <= 1'b0;
                r_phase  <= i_settled;
            end else begin
                r_count <= r_count + 1'b1;
                r_phase <= ~r_phase;
            end
        end else if (r_active) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    assign o_phase = r_phase;
    assign o_done  = w_last;

endmodule

// File: rtl/key_matrix_emulator.sv
// Keyboard end of the 4x8 row/column scan with programmable contact bounce.
// Define MATRIX_GHOST_EN to emulate a diode-less matrix with one-hop ghosting.
//
// state     | meaning
// ST_IDLE   | settled, cmd_ready high, commands accepted
// ST_BOUNCE | key tgt bouncing, cmd_ready low
module key_matrix_emulator
    import piano_kbd_pkg::*;
#(
    parameter int TOGGLE_CYCLES  = 50000,
    parameter int BOUNCE_TOGGLES = 4
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] columns,
    key_matrix_emulator_if.slave cmd,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                bouncing
);

    emu_state_t          r_state;
    logic [NUM_KEYS-1:0] r_key_state;
    logic [NUM_COLS-1:0] r_columns;
    logic                r_cmd_ready;
    logic                r_bouncing;
    key_idx_t            r_tgt;

    logic                w_accept;
    logic                w_change;
    logic                w_start;
    logic                w_phase;
    logic                w_done;
    logic [NUM_KEYS-1:0] w_eff;
    logic [NUM_COLS-1:0] w_pull;

    assign w_accept = cmd.cmd_valid && r_cmd_ready;
    assign w_change = (cmd.cmd_press != r_key_state[cmd.cmd_key]);
    assign w_start  = w_accept && w_change && (BOUNCE_TOGGLES > 0);

    key_bounce_gen #(
        .TOGGLE_CYCLES  (TOGGLE_CYCLES),
        .BOUNCE_TOGGLES (BOUNCE_TOGGLES)
    ) u_bounce (
        .i_clk        (CLOCK_50),
        .i_rst_n      (resetn),
        .i_start      (w_start),
        .i_phase_init (cmd.cmd_press),
        .i_settled    (r_key_state[r_tgt]),
        .o_phase      (w_phase),
        .o_done       (w_done)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_key_state <= '0;
            r_cmd_ready <= 1'b0;
            r_bouncing  <= 1'b0;
            r_tgt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept && w_change) begin
                        r_key_state[cmd.cmd_key] <= cmd.cmd_press;
                        if (BOUNCE_TOGGLES > 0) begin
                            r_tgt       <= cmd.cmd_key;
                            r_state     <= ST_BOUNCE;
                            r_cmd_ready <= 1'b0;
                            r_bouncing  <= 1'b1;
                        end
                    end
                end
                ST_BOUNCE: begin
                    if (w_done) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_bouncing  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_eff = r_key_state;
        if (r_state == ST_BOUNCE) w_eff[r_tgt] = w_phase;
    end

    always_comb begin
        w_pull = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (!rows[r] && w_eff[key_idx(r, c)]) w_pull[c] = 1'b1;
`ifdef MATRIX_GHOST_EN
                // Current sneaks through a rectangle of three closed contacts.
                for (int rp = 0; rp < NUM_ROWS; rp++) begin
                    for (int cp = 0; cp < NUM_COLS; cp++) begin
                        if (!rows[r] && w_eff[key_idx(r, cp)] && w_eff[key_idx(rp, cp)]
                            && w_eff[key_idx(rp, c)]) w_pull[c] = 1'b1;
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) r_columns <= '1;
        else         r_columns <= ~w_pull;
    end

    assign columns       = r_columns;
    assign key_state     = r_key_state;
    assign bouncing      = r_bouncing;
    assign cmd.cmd_ready = r_cmd_ready;

endmodule

// File: tb/tb_key_matrix_emulator.sv
// Bench for key_matrix_emulator: one instance without bounce, one with a short bounce profile.
`timescale 1ns/1ps
module tb_key_matrix_emulator;
    import piano_kbd_pkg::*;

    typedef struct {
        logic [3:0] rows;
        logic [7:0] cols;
    } vec_t;

    typedef struct {
        logic col0;
        logic bnc;
        logic rdy;
    } exp_b_t;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic [3:0]  rows_nb, rows_b;
    logic [7:0]  cols_nb, cols_b;
    logic [31:0] ks_nb, ks_b;
    logic        bnc_nb, bnc_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    vec_t         tbl[$];
    logic [7:0]   exp_q[$];
    exp_b_t       exp_b_q[$];
    exp_b_t       eb;

    key_matrix_emulator_if if_nb ();
    key_matrix_emulator_if if_b ();

    key_matrix_emulator #(.TOGGLE_CYCLES(4), .BOUNCE_TOGGLES(0)) u_dut_nb (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .rows      (rows_nb),
        .columns   (cols_nb),
        .cmd       (if_nb),
        .key_state (ks_nb),
        .bouncing  (bnc_nb)
    );

    key_matrix_emulator #(.TOGGLE_CYCLES(4), .BOUNCE_TOGGLES(3)) u_dut_b (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .rows      (rows_b),
        .columns   (cols_b),
        .cmd       (if_b),
        .key_state (ks_b),
        .bouncing  (bnc_b)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Returns at the falling edge right after the accepting rising edge.
    task automatic send_cmd(input bit sel_b, input logic [4:0] key, input logic press);
        bit ok = 1'b0;
        if (sel_b) begin
            if_b.cmd_valid = 1'b1; if_b.cmd_key = key; if_b.cmd_press = press;
        end else begin
            if_nb.cmd_valid = 1'b1; if_nb.cmd_key = key; if_nb.cmd_press = press;
        end
        for (int k = 0; k < 64 && !ok; k++) begin
            if ((sel_b ? if_b.cmd_ready : if_nb.cmd_ready) === 1'b1) begin
                ok = 1'b1;
                @(posedge CLOCK_50);
            end else begin
                @(negedge CLOCK_50);
            end
        end
        @(negedge CLOCK_50);
        if (sel_b) if_b.cmd_valid = 1'b0;
        else       if_nb.cmd_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_accept_timeout: key %0d not accepted within 64 cycles", key);
        end
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            rows_nb = tbl[i].rows;
            exp_q.push_back(tbl[i].cols);
            @(negedge CLOCK_50);
            check($sformatf("%s[%0d]", name, i), {24'h0, cols_nb}, {24'h0, exp_q.pop_front()});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        rows_nb = 4'b1110;
        rows_b  = 4'b1110;
        if_nb.cmd_valid = 1'b0; if_nb.cmd_key = '0; if_nb.cmd_press = 1'b0;
        if_b.cmd_valid  = 1'b0; if_b.cmd_key  = '0; if_b.cmd_press  = 1'b0;

        repeat (3) @(negedge CLOCK_50);
        check("rst_cols_nb", {24'h0, cols_nb}, 32'hFF);
        check("rst_cols_b", {24'h0, cols_b}, 32'hFF);
        check("rst_keys_nb", ks_nb, 32'h0);
        check("rst_ready_b", {31'h0, if_b.cmd_ready}, 32'h0);
        check("rst_bouncing_b", {31'h0, bnc_b}, 32'h0);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        check("rel_ready_nb", {31'h0, if_nb.cmd_ready}, 32'h1);
        check("rel_ready_b", {31'h0, if_b.cmd_ready}, 32'h1);

        // Bounce-free instance: key 10 is row 1, column 2.
        send_cmd(1'b0, 5'd10, 1'b1);
        check("nb_press10_keys", ks_nb, 32'h0000_0400);
        check("nb_press10_ready", {31'h0, if_nb.cmd_ready}, 32'h1);
        tbl.delete();
        tbl.push_back('{4'b1101, 8'hFB});
        tbl.push_back('{4'b1110, 8'hFF});
        tbl.push_back('{4'b1111, 8'hFF});
        tbl.push_back('{4'b1100, 8'hFB});
        tbl.push_back('{4'b0111, 8'hFF});
        tbl.push_back('{4'b0000, 8'hFB});
        run_table("nb_key10");

        send_cmd(1'b0, 5'd10, 1'b0);
        check("nb_release10_keys", ks_nb, 32'h0);
        send_cmd(1'b0, 5'd0, 1'b1);
        send_cmd(1'b0, 5'd1, 1'b1);
        send_cmd(1'b0, 5'd8, 1'b1);
        check("nb_keys_0_1_8", ks_nb, 32'h0000_0103);
        check("nb_never_bounces", {31'h0, bnc_nb}, 32'h0);
        tbl.delete();
`ifdef MATRIX_GHOST_EN
        tbl.push_back('{4'b1101, 8'hFC});
`else
        tbl.push_back('{4'b1101, 8'hFE});
`endif
        tbl.push_back('{4'b1110, 8'hFC});
        tbl.push_back('{4'b1100, 8'hFC});
        tbl.push_back('{4'b1111, 8'hFF});
        tbl.push_back('{4'b1011, 8'hFF});
        run_table("nb_ghost");

        // Bounce profile: 4 cycles per phase, 3 toggles, column lags eff by one cycle.
        rows_b = 4'b1110;
        for (int i = 0; i < 16; i++) begin
            eb.col0 = (i == 0) ? 1'b1 : (i <= 4) ? 1'b0 : (i <= 8) ? 1'b1 : 1'b0;
            eb.bnc  = (i < 12);
            eb.rdy  = (i >= 12);
            exp_b_q.push_back(eb);
        end
        send_cmd(1'b1, 5'd0, 1'b1);
        check("b_press0_keys", ks_b, 32'h1);
        for (int i = 0; i < 16; i++) begin
            eb = exp_b_q.pop_front();
            check($sformatf("b_col0[%0d]", i), {31'h0, cols_b[0]}, {31'h0, eb.col0});
            check($sformatf("b_bouncing[%0d]", i), {31'h0, bnc_b}, {31'h0, eb.bnc});
            check($sformatf("b_ready[%0d]", i), {31'h0, if_b.cmd_ready}, {31'h0, eb.rdy});
            @(negedge CLOCK_50);
        end

        send_cmd(1'b1, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b_redundant_bouncing[%0d]", i), {31'h0, bnc_b}, 32'h0);
            check($sformatf("b_redundant_ready[%0d]", i), {31'h0, if_b.cmd_ready}, 32'h1);
            @(negedge CLOCK_50);
        end
        check("b_redundant_keys", ks_b, 32'h1);

        // Reset in the middle of a bounce sequence.
        send_cmd(1'b1, 5'd5, 1'b1);
        repeat (5) @(negedge CLOCK_50);
        check("b_midbounce_active", {31'h0, bnc_b}, 32'h1);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        check("b_midrst_keys", ks_b, 32'h0);
        check("b_midrst_bouncing", {31'h0, bnc_b}, 32'h0);
        check("b_midrst_cols", {24'h0, cols_b}, 32'hFF);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        check("b_midrst_ready", {31'h0, if_b.cmd_ready}, 32'h1);

        send_cmd(1'b1, 5'd3, 1'b1);
        check("b_post_keys", ks_b, 32'h8);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 1) check("b_post_col3_first", {24'h0, cols_b}, 32'hF7);
            if (bnc_b !== 1'b1) break;
            cnt++;
            @(negedge CLOCK_50);
        end
        check("b_post_bounce_len", cnt, 32'd12);
        check("b_post_settled_cols", {24'h0, cols_b}, 32'hF7);
        check("b_post_ready", {31'h0, if_b.cmd_ready}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
